// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN input spike generator.
// lfsr_step is the single definition of the Galois shift used by the LFSR.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GEN     = 2'd1,
    PRESENT = 2'd2
  } spike_gen_state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] shifted;
    shifted = v >> 1;
    return v[0] ? (shifted ^ LFSR_MASK) : shifted;
  endfunction

endpackage

// File: rtl/snn_lfsr32.sv
// 32-bit right-shifting Galois LFSR; a zero seed is forced to 1 so the
// register can never lock up in the all-zero state.
module snn_lfsr32
  import snn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (en) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/snn_input_spike_gen.sv
// Bernoulli spike encoder: one input evaluated per GEN cycle against a shared
// LFSR, full vector presented once per timestep on a valid/ready port.
module snn_input_spike_gen
  import snn_pkg::*;
#(
  parameter int          NUM_INPUTS = 9,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
  parameter int          STEP_W     = 16,
  localparam int         IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [IDX_W-1:0]      cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic [STEP_W-1:0]     num_steps,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_W-1:0]     step_count,
  output logic                  spike_valid,
  input  logic                  spike_ready,
  output logic [NUM_INPUTS-1:0] spike_out,
  output spike_gen_state_t      state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  spike_gen_state_t        state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [STEP_W-1:0]       step_q, step_d, step_inc;
  logic [STEP_W-1:0]       steps_lat_q, steps_lat_d;
  logic [NUM_INPUTS-1:0]   shadow_q, shadow_d;
  logic [NUM_INPUTS-1:0]   spike_q, spike_d;
  logic                    done_d;
  logic                    lfsr_en;
  logic                    fire;
  logic [31:0]             lfsr_value;
  logic [DATA_WIDTH-1:0]   rate_q [NUM_INPUTS];

  // Rate table is independent of the FSM so the CPU can retune mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) rate_q[i] <= '0;
    end else if (cfg_wr_en && (int'(cfg_wr_addr) < NUM_INPUTS)) begin
      rate_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  snn_lfsr32 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .value (lfsr_value)
  );

  // Handshake: spike_valid/spike_out stay frozen in PRESENT until a cycle with
  // spike_valid && spike_ready; that edge transfers the vector.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    step_d      = step_q;
    steps_lat_d = steps_lat_q;
    shadow_d    = shadow_q;
    spike_d     = spike_q;
    done_d      = 1'b0;
    lfsr_en     = 1'b0;
    step_inc    = step_q + STEP_W'(1);
    fire        = (DATA_WIDTH'(lfsr_value) <= rate_q[idx_q]);
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_steps != '0) begin
              state_d     = GEN;
              idx_d       = '0;
              step_d      = '0;
              steps_lat_d = num_steps;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        GEN: begin
          lfsr_en          = 1'b1;
          shadow_d[idx_q]  = fire;
          if (idx_q == LAST_IDX) begin
            state_d = PRESENT;
            spike_d = shadow_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        PRESENT: begin
          if (spike_ready) begin
            step_d = step_inc;
            if (step_inc == steps_lat_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GEN;
              idx_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      step_q      <= '0;
      steps_lat_q <= '0;
      shadow_q    <= '0;
      spike_q     <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      step_q      <= step_d;
      steps_lat_q <= steps_lat_d;
      shadow_q    <= shadow_d;
      spike_q     <= spike_d;
      done        <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign spike_valid = (state_q == PRESENT);
  assign spike_out   = spike_q;
  assign step_count  = step_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_snn_input_spike_gen.sv
// Directed bench for snn_input_spike_gen with an independent rate/LFSR
// reference model predicting every spike vector.
module tb_snn_input_spike_gen;
  import snn_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr_en = 1'b0;
  logic [3:0]       cfg_wr_addr = '0;
  logic [31:0]      cfg_wr_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [15:0]      num_steps = '0;
  logic             busy, done, spike_valid;
  logic             spike_ready = 1'b1;
  logic [15:0]      step_count;
  logic [8:0]       spike_out;
  spike_gen_state_t state_dbg;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] lfsr_m = 32'h1;
  logic [31:0] rate_m [9];
  logic [8:0]  exp_v;

  snn_input_spike_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .start       (start),
    .stop        (stop),
    .num_steps   (num_steps),
    .busy        (busy),
    .done        (done),
    .step_count  (step_count),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_out   (spike_out),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic model_vec(output logic [8:0] v);
    for (int i = 0; i < 9; i++) begin
      v[i]   = (lfsr_m <= rate_m[i]);
      lfsr_m = lfsr_next(lfsr_m);
    end
  endtask

  task automatic write_rate(input int idx, input logic [31:0] val);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'(idx);
    cfg_wr_data = val;
    tick();
    cfg_wr_en = 1'b0;
    if (idx < 9) rate_m[idx] = val;
  endtask

  task automatic pulse_start(input int n);
    num_steps = 16'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(spike_valid), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
  endtask

  // Full run with ready held high; every vector checked against the model.
  task automatic run_steps(input string tag, input int n, input bit bit0_zero);
    int cyc, got, last_v;
    logic [8:0] ev;
    spike_ready = 1'b1;
    pulse_start(n);
    cyc = 0; got = 0; last_v = -1;
    while (got < n && cyc < n * 10 + 50) begin
      if (spike_valid) begin
        model_vec(ev);
        if (last_v < 0) check({tag, "_latency"}, 64'(cyc), 64'd9);
        else            check({tag, "_spacing"}, 64'(cyc - last_v), 64'd10);
        last_v = cyc;
        check({tag, "_vector"}, 64'(spike_out), 64'(ev));
        if (bit0_zero) check({tag, "_bit0"}, 64'(spike_out[0]), 64'd0);
        got++;
      end
      tick();
      cyc++;
      check({tag, "_step_count"}, 64'(step_count), 64'(got));
    end
    check({tag, "_completed"}, 64'(got), 64'(n));
    check({tag, "_done"}, 64'(done), 64'd1);
    check_idle_outputs({tag, "_end"});
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_step_hold"}, 64'(step_count), 64'(n));
  endtask

  initial begin
    for (int i = 0; i < 9; i++) rate_m[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_done", 64'(done), 64'd0);
    check("reset_spike_out", 64'(spike_out), 64'd0);
    check("reset_step_count", 64'(step_count), 64'd0);
    rst = 1'b0;
    tick();

    // 1: all rates zero; out-of-range address must not alias onto a real input
    write_rate(9, 32'hFFFF_FFFF);
    write_rate(15, 32'hFFFF_FFFF);
    run_steps("zero_rates", 4, 1'b1);

    // 2: all rates saturated
    for (int i = 0; i < 9; i++) write_rate(i, 32'hFFFF_FFFF);
    run_steps("full_rates", 3, 1'b0);

    // 3: graded rates, long run
    for (int i = 0; i < 9; i++) write_rate(i, 32'h1C71_C71C * 32'(i));
    run_steps("graded", 100, 1'b1);

    // 4: backpressure, with a start while busy that must be ignored
    spike_ready = 1'b0;
    pulse_start(2);
    repeat (8) tick();
    check("bp_valid_early", 64'(spike_valid), 64'd0);
    tick();
    model_vec(exp_v);
    check("bp_valid", 64'(spike_valid), 64'd1);
    check("bp_vector", 64'(spike_out), 64'(exp_v));
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        num_steps = 16'd50;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      check("bp_hold_valid", 64'(spike_valid), 64'd1);
      check("bp_hold_vector", 64'(spike_out), 64'(exp_v));
      check("bp_hold_step", 64'(step_count), 64'd0);
    end
    spike_ready = 1'b1;
    tick();
    check("bp_accept_step", 64'(step_count), 64'd1);
    check("bp_accept_valid", 64'(spike_valid), 64'd0);
    repeat (9) tick();
    model_vec(exp_v);
    check("bp_second_valid", 64'(spike_valid), 64'd1);
    check("bp_second_vector", 64'(spike_out), 64'(exp_v));
    tick();
    check("bp_done", 64'(done), 64'd1);
    check("bp_final_step", 64'(step_count), 64'd2);
    tick();

    // 5: zero-step run completes immediately without ever going busy
    pulse_start(0);
    check("zero_done", 64'(done), 64'd1);
    check_idle_outputs("zero");
    tick();
    check("zero_done_pulse", 64'(done), 64'd0);
    check_idle_outputs("zero_after");

    // 6: stop mid-GEN of step 2, LFSR carries over, then async reset mid-PRESENT
    spike_ready = 1'b1;
    pulse_start(5);
    repeat (9) tick();
    model_vec(exp_v);
    check("stop_first_vector", 64'(spike_out), 64'(exp_v));
    tick();
    check("stop_step1", 64'(step_count), 64'd1);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) lfsr_m = lfsr_next(lfsr_m);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_outputs("stop");
    check("stop_done", 64'(done), 64'd0);
    check("stop_step_keep", 64'(step_count), 64'd1);
    tick();
    check("stop_no_done", 64'(done), 64'd0);

    spike_ready = 1'b0;
    pulse_start(3);
    repeat (9) tick();
    model_vec(exp_v);
    check("resume_valid", 64'(spike_valid), 64'd1);
    check("resume_vector", 64'(spike_out), 64'(exp_v));
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_spike_out", 64'(spike_out), 64'd0);
    check("async_rst_step", 64'(step_count), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    lfsr_m = 32'h1;
    for (int i = 0; i < 9; i++) rate_m[i] = '0;
    tick();
    run_steps("post_rst", 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
